integer_datapath_pipe: RTL and testbench
========================================

Name: integer_datapath_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle integer datapath.
- Contains a 2^ADDR_W x DATA_W register file, an S/DS operand select, a registered ALU stage with write-back, and registered C/N/Z flags.
- Accepts one operation per clock under a valid qualifier, with an optional EX-to-read forwarding path.
- Sits between the control FSM and the memory/IO path of the RISC16 core.

Parameters:
DATA_W, 16, datapath and register width (>=4)
ADDR_W, 3, register address width; register count = 2^ADDR_W

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation present this cycle
we  in  1  write result to W_adr (qualified by in_valid)
W_adr  in  ADDR_W  write-back register
R_adr  in  ADDR_W  R operand register
S_adr  in  ADDR_W  S operand register
DS  in  DATA_W  external data operand
sel  in  1  1: S operand = DS, 0: S operand = reg[S_adr]
ALU_OP  in  4  operation code
out_valid  out  1  result valid
Alu_Out  out  DATA_W  registered ALU result
Reg_Out  out  DATA_W  registered R operand used by the reported op
C, N, Z  out  1 each  registered flags

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers, EX-stage latches, Alu_Out, Reg_Out, out_valid, C, N and Z go to 0.
  - An in-flight op is discarded; no register write occurs.
- Stage 1 (RD), cycle N:
  - Read R=reg[R_adr] and S=(sel ? DS : reg[S_adr]) combinationally.
  - Latch R, S, ALU_OP, W_adr and we&in_valid into EX registers; set ex_valid=in_valid.
- Stage 2 (EX), cycle N+1:
  - ALU computes Y from the latched operands.
  - At the end of cycle N+1, when ex_valid: Alu_Out<=Y, Reg_Out<=R, flags update, out_valid<=1, and reg[W_adr]<=Y if ex_we.
  - When !ex_valid: out_valid<=0 and Alu_Out, Reg_Out and flags hold.
- Latency: in_valid at edge N gives out_valid at edge N+2. Throughput is 1 op/cycle. There is no backpressure.
- ALU ops (arithmetic modulo 2^DATA_W):
  - 0 Y=R; 1 Y=S; 2 R+S; 3 R-S; 4 R+1; 5 R-1; 6 R&S; 7 R|S; 8 R^S; 9 ~R; 10 R<<1; 11 R>>1 logical; 12 R>>>1 arithmetic; 13 0-R; 14/15 reserved, Y=R.
- Flags:
  - C: carry-out for 2 and 4; borrow (R<S unsigned) for 3; borrow for 5 (R==0); the bit shifted out for 10/11/12; 1 for 13 when R!=0; 0 otherwise.
  - N=Y[DATA_W-1]; Z=(Y==0).
- Read/write collision with forwarding on: an RD read of register k while EX writes k in the same cycle returns the new Y (see Optional Feature). This applies to R and S (sel=0) independently.
- Same-edge write and read of the same address from outside: the write wins at the edge; there is no double-write hazard because the write port is single.
- Register 0 is an ordinary writable register.
- X/unused inputs are ignored when in_valid=0.

Optional Feature:
- INTDP_FWD_EN defined:
  - A combinational bypass muxes the EX result into the RD operand when ex_valid & ex_we & (W_adr_ex == R_adr or S_adr).
  - Back-to-back dependent ops get the correct operands.
- INTDP_FWD_EN undefined:
  - No bypass; RD reads the pre-write register value.
  - Software inserts one bubble between dependent ops.
  - Everything else is identical.

Test Plan:
1. Reset: hold reset=0 mid-stream with in_valid=1 -> all outputs 0, out_valid=0, register read-back 0. Release -> first op output appears 2 cycles after its in_valid.
2. Load/add: DS=0x0005, sel=1, op1, we, W=1; then DS=0x0007 to W=2; then R=1, S=2, op2, W=3, separated by bubbles -> Alu_Out=0x000C, C=0, N=0, Z=0; reg3=0x000C.
3. Boundaries:
   - R=0xFFFF op4 -> Y=0x0000, C=1, Z=1.
   - R=0x0000 S=0x0001 op3 -> Y=0xFFFF, C=1, N=1.
   - R=0x8001 op12 -> Y=0xC000, C=1.
4. Forwarding: op A writes reg1=0x0010; next cycle op2 R=1 S=1 W=1 -> with INTDP_FWD_EN Alu_Out=0x0020; without it, uses the stale reg1 value.
5. Bubbles/holds: in_valid pattern 1,0,1 -> out_valid 1,0,1 two cycles later; Alu_Out and flags hold during the 0; we=1 with in_valid=0 writes nothing.
6. Parametrisation: DATA_W=8, ADDR_W=4 -> write/read all 16 registers; 0xFF+0x01 gives Y=0x00, C=1, Z=1.

Source files
------------

// File: rtl/integer_datapath_pipe.sv
// integer_datapath_pipe: two-stage (RD -> EX) integer datapath for the RISC16 core.
// The register file is 2^ADDR_W x DATA_W. The S operand comes either from the
// register file or from DS. The ALU result is registered and written back, and
// the C/N/Z flags are registered.
// Optional feature: define INTDP_FWD_EN to bypass the EX result into the RD
// operands. Without it, a dependent op needs one bubble before it.
module integer_datapath_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] W_adr,
  input  logic [ADDR_W-1:0] R_adr,
  input  logic [ADDR_W-1:0] S_adr,
  input  logic [DATA_W-1:0] DS,
  input  logic              sel,
  input  logic [3:0]        ALU_OP,
  output logic              out_valid,
  output logic [DATA_W-1:0] Alu_Out,
  output logic [DATA_W-1:0] Reg_Out,
  output logic              C,
  output logic              N,
  output logic              Z
);

  localparam int REGS = 1 << ADDR_W;
  localparam logic [DATA_W:0] ONE_W = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] rf [REGS];

  // EX-stage latches
  logic              ex_valid;
  logic              ex_we;
  logic [ADDR_W-1:0] ex_wadr;
  logic [3:0]        ex_op;
  logic [DATA_W-1:0] ex_r;
  logic [DATA_W-1:0] ex_s;

  // ALU result and carry for the op currently in EX
  logic [DATA_W-1:0] y;
  logic              c_y;

  // RD operands
  logic              fwd_r;
  logic              fwd_s;
  logic [DATA_W-1:0] rd_r;
  logic [DATA_W-1:0] rd_s;

`ifdef INTDP_FWD_EN
  // Bypass: this cycle's EX write lands on a register that RD is reading now.
  assign fwd_r = ex_valid && ex_we && (ex_wadr == R_adr);
  assign fwd_s = ex_valid && ex_we && (ex_wadr == S_adr);
`else
  assign fwd_r = 1'b0;
  assign fwd_s = 1'b0;
`endif

  // RD stage: read the operands combinationally, taking the bypass when it applies.
  always_comb begin
    rd_r = fwd_r ? y : rf[R_adr];
    rd_s = sel ? DS : (fwd_s ? y : rf[S_adr]);
  end

  // RD -> EX pipeline register. A cycle without in_valid becomes a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_we    <= 1'b0;
      ex_wadr  <= '0;
      ex_op    <= '0;
      ex_r     <= '0;
      ex_s     <= '0;
    end else begin
      // NOTE: sequential state always takes <=; every reader sees the pre-edge value.
      ex_valid <= in_valid;
      ex_we    <= we && in_valid;
      ex_wadr  <= W_adr;
      ex_op    <= ALU_OP;
      ex_r     <= rd_r;
      ex_s     <= rd_s;
    end
  end

  // EX stage ALU. All arithmetic is modulo 2^DATA_W, and c_y carries the flag bit.
  always_comb begin
    // NOTE: default every output first, otherwise an uncovered path infers a latch.
    y   = ex_r;
    c_y = 1'b0;
    case (ex_op)
      4'd0:  y = ex_r;
      4'd1:  y = ex_s;
      4'd2:  {c_y, y} = {1'b0, ex_r} + {1'b0, ex_s};
      4'd3:  {c_y, y} = {1'b0, ex_r} - {1'b0, ex_s};
      4'd4:  {c_y, y} = {1'b0, ex_r} + ONE_W;
      4'd5: begin
        y   = ex_r - ONE_W[DATA_W-1:0];
        c_y = (ex_r == '0);
      end
      4'd6:  y = ex_r & ex_s;
      4'd7:  y = ex_r | ex_s;
      4'd8:  y = ex_r ^ ex_s;
      4'd9:  y = ~ex_r;
      4'd10: begin
        y   = {ex_r[DATA_W-2:0], 1'b0};
        c_y = ex_r[DATA_W-1];
      end
      4'd11: begin
        y   = {1'b0, ex_r[DATA_W-1:1]};
        c_y = ex_r[0];
      end
      4'd12: begin
        y   = {ex_r[DATA_W-1], ex_r[DATA_W-1:1]};
        c_y = ex_r[0];
      end
      4'd13: begin
        y   = '0 - ex_r;
        c_y = (ex_r != '0);
      end
      default: y = ex_r;
    endcase
  end

  // Register file write-back from EX. The file has a single write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this file is cleared on reset, so it stays in flops and is not mapped to RAM.
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
    end else if (ex_valid && ex_we) begin
      rf[ex_wadr] <= y;
    end
  end

  // Output registers. Results and flags hold across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Alu_Out   <= '0;
      Reg_Out   <= '0;
      C         <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      out_valid <= ex_valid;
      if (ex_valid) begin
        Alu_Out <= y;
        Reg_Out <= ex_r;
        C       <= c_y;
        N       <= y[DATA_W-1];
        Z       <= (y == '0);
      end
    end
  end

endmodule

// File: tb/tb_integer_datapath_pipe.sv
// Directed testbench for integer_datapath_pipe. It drives a 16-bit/8-register
// instance and an 8-bit/16-register instance. Expected values are computed by hand.
module tb_integer_datapath_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid, we, sel;
  logic [2:0]  W_adr, R_adr, S_adr;
  logic [15:0] DS;
  logic [3:0]  ALU_OP;
  logic        out_valid, C, N, Z;
  logic [15:0] Alu_Out, Reg_Out;

  // 8-bit / 16-register instance
  logic        p8_in_valid, p8_we, p8_sel;
  logic [3:0]  p8_w_adr, p8_r_adr, p8_s_adr;
  logic [7:0]  p8_ds;
  logic [3:0]  p8_op;
  logic        p8_out_valid, p8_c, p8_n, p8_z;
  logic [7:0]  p8_alu, p8_reg;

  integer_datapath_pipe #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .we(we), .W_adr(W_adr),
    .R_adr(R_adr), .S_adr(S_adr), .DS(DS), .sel(sel), .ALU_OP(ALU_OP),
    .out_valid(out_valid), .Alu_Out(Alu_Out), .Reg_Out(Reg_Out), .C(C), .N(N), .Z(Z)
  );

  integer_datapath_pipe #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(p8_in_valid), .we(p8_we), .W_adr(p8_w_adr),
    .R_adr(p8_r_adr), .S_adr(p8_s_adr), .DS(p8_ds), .sel(p8_sel), .ALU_OP(p8_op),
    .out_valid(p8_out_valid), .Alu_Out(p8_alu), .Reg_Out(p8_reg), .C(p8_c), .N(p8_n), .Z(p8_z)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one RD-stage op, then advance to the next falling edge.
  task automatic drive(input logic v, input logic w_en, input logic [2:0] wa,
                       input logic [2:0] ra, input logic [2:0] sa, input logic [15:0] ds_i,
                       input logic sel_i, input logic [3:0] op_i);
    in_valid = v; we = w_en; W_adr = wa; R_adr = ra; S_adr = sa;
    DS = ds_i; sel = sel_i; ALU_OP = op_i;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 4'd0);
  endtask

  task automatic drive8(input logic v, input logic w_en, input logic [3:0] wa,
                        input logic [3:0] ra, input logic [7:0] ds_i,
                        input logic sel_i, input logic [3:0] op_i);
    p8_in_valid = v; p8_we = w_en; p8_w_adr = wa; p8_r_adr = ra; p8_s_adr = 4'd0;
    p8_ds = ds_i; p8_sel = sel_i; p8_op = op_i;
    @(negedge clk);
  endtask

  // Table of independent ops with their expected result and carry.
  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  r;
    logic        sel;
    logic [15:0] ds;
    logic [15:0] y;
    logic        c;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic check_vec(input int i);
    string t;
    t = $sformatf("vec%0d_op%0d", i, tbl[i].op);
    check({t, "_y"}, {16'h0, Alu_Out}, {16'h0, tbl[i].y});
    check({t, "_cnz"}, {29'h0, C, N, Z}, {29'h0, tbl[i].c, tbl[i].y[15], tbl[i].y == 16'h0});
    check({t, "_ov"}, {31'h0, out_valid}, 32'd1);
  endtask

  logic [15:0] fwd_exp;

  initial begin
    // Register contents when the table runs:
    // r0=0, r1=5, r2=7, r3=000C, r4=FFFF, r5=8001.
    tbl[0]  = '{4'd4,  3'd4, 1'b0, 16'h0000, 16'h0000, 1'b1};
    tbl[1]  = '{4'd3,  3'd0, 1'b1, 16'h0001, 16'hFFFF, 1'b1};
    tbl[2]  = '{4'd12, 3'd5, 1'b0, 16'h0000, 16'hC000, 1'b1};
    tbl[3]  = '{4'd11, 3'd5, 1'b0, 16'h0000, 16'h4000, 1'b1};
    tbl[4]  = '{4'd10, 3'd5, 1'b0, 16'h0000, 16'h0002, 1'b1};
    tbl[5]  = '{4'd13, 3'd5, 1'b0, 16'h0000, 16'h7FFF, 1'b1};
    tbl[6]  = '{4'd13, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[7]  = '{4'd5,  3'd0, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    tbl[8]  = '{4'd5,  3'd1, 1'b0, 16'h0000, 16'h0004, 1'b0};
    tbl[9]  = '{4'd2,  3'd4, 1'b1, 16'h0001, 16'h0000, 1'b1};
    tbl[10] = '{4'd3,  3'd2, 1'b1, 16'h0005, 16'h0002, 1'b0};
    tbl[11] = '{4'd6,  3'd5, 1'b1, 16'h00FF, 16'h0001, 1'b0};
    tbl[12] = '{4'd7,  3'd1, 1'b1, 16'h000A, 16'h000F, 1'b0};
    tbl[13] = '{4'd8,  3'd4, 1'b1, 16'h00FF, 16'hFF00, 1'b0};
    tbl[14] = '{4'd9,  3'd1, 1'b0, 16'h0000, 16'hFFFA, 1'b0};
    tbl[15] = '{4'd0,  3'd2, 1'b0, 16'h0000, 16'h0007, 1'b0};
    tbl[16] = '{4'd1,  3'd0, 1'b1, 16'h1234, 16'h1234, 1'b0};
    tbl[17] = '{4'd14, 3'd2, 1'b0, 16'h0000, 16'h0007, 1'b0};
    tbl[18] = '{4'd15, 3'd1, 1'b0, 16'h0000, 16'h0005, 1'b0};

    reset = 1'b0;
    in_valid = 0; we = 0; W_adr = 0; R_adr = 0; S_adr = 0; DS = 0; sel = 0; ALU_OP = 0;
    p8_in_valid = 0; p8_we = 0; p8_w_adr = 0; p8_r_adr = 0; p8_s_adr = 0;
    p8_ds = 0; p8_sel = 0; p8_op = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", {out_valid, C, N, Z, Alu_Out, Reg_Out}, 36'h0);
    reset = 1'b1;

    // --- Reset taken mid-stream with an op in flight ---
    drive(1, 1, 3'd1, 0, 0, 16'h1234, 1, 4'd1);
    idle();
    check("pre_rst_alu", {16'h0, Alu_Out}, 32'h1234);
    drive(1, 1, 3'd2, 0, 0, 16'hBEEF, 1, 4'd1);   // now sits in EX
    reset = 1'b0;                                   // async, in_valid still 1
    #1;
    check("rst_async", {out_valid, C, N, Z, Alu_Out, Reg_Out}, 36'h0);
    repeat (2) @(negedge clk);
    check("rst_hold", {out_valid, C, N, Z, Alu_Out, Reg_Out}, 36'h0);
    in_valid = 1'b0; we = 1'b0;
    reset = 1'b1;
    drive(1, 0, 0, 3'd1, 0, 0, 0, 4'd0);            // read reg1
    check("lat_edge1_ov", {31'h0, out_valid}, 32'd0);
    drive(1, 0, 0, 3'd2, 0, 0, 0, 4'd0);            // read reg2
    check("lat_edge2_ov", {31'h0, out_valid}, 32'd1);
    check("rst_reg1", {16'h0, Alu_Out}, 32'h0);
    check("rst_reg1_z", {31'h0, Z}, 32'd1);
    idle();
    check("rst_reg2_discarded", {16'h0, Alu_Out}, 32'h0);

    // --- Load and add ---
    drive(1, 1, 3'd1, 0, 0, 16'h0005, 1, 4'd1); idle();
    drive(1, 1, 3'd2, 0, 0, 16'h0007, 1, 4'd1); idle();
    drive(1, 1, 3'd3, 3'd1, 3'd2, 16'h0, 0, 4'd2); idle();
    check("add_y", {16'h0, Alu_Out}, 32'h000C);
    check("add_cnz", {29'h0, C, N, Z}, 32'h0);
    check("add_regout", {16'h0, Reg_Out}, 32'h0005);
    drive(1, 1, 3'd4, 0, 0, 16'hFFFF, 1, 4'd1);
    drive(1, 1, 3'd5, 0, 0, 16'h8001, 1, 4'd1);
    drive(1, 0, 0, 3'd3, 0, 0, 0, 4'd0);            // read reg3
    idle();
    check("reg3_rb", {16'h0, Alu_Out}, 32'h000C);

    // --- Independent ops issued back to back ---
    for (int i = 0; i < NV; i++) begin
      drive(1, 0, 0, tbl[i].r, 0, tbl[i].ds, tbl[i].sel, tbl[i].op);
      if (i > 0) check_vec(i - 1);
    end
    idle();
    check_vec(NV - 1);

    // --- Forwarding: a dependent op issued straight after its producer ---
    drive(1, 1, 3'd1, 0, 0, 16'h0010, 1, 4'd1);
    drive(1, 1, 3'd1, 3'd1, 3'd1, 16'h0, 0, 4'd2);
    check("fwd_prod_y", {16'h0, Alu_Out}, 32'h0010);
`ifdef INTDP_FWD_EN
    fwd_exp = 16'h0020;
`else
    fwd_exp = 16'h000A;                             // stale reg1 = 5
`endif
    idle();
    check("fwd_dep_y", {16'h0, Alu_Out}, {16'h0, fwd_exp});
    idle();
    drive(1, 0, 0, 3'd1, 0, 0, 0, 4'd0); idle();
    check("fwd_reg1_rb", {16'h0, Alu_Out}, {16'h0, fwd_exp});

    // --- Bubbles: outputs hold, and an unqualified we writes nothing ---
    drive(1, 0, 0, 3'd4, 0, 16'h0001, 1, 4'd2);     // FFFF+1 -> 0, C=1, Z=1
    drive(0, 1, 3'd6, 0, 0, 16'h9999, 1, 4'd1);
    check("bub_ov1", {31'h0, out_valid}, 32'd1);
    drive(1, 0, 0, 0, 0, 16'h0066, 1, 4'd1);
    check("bub_ov0", {31'h0, out_valid}, 32'd0);
    check("bub_hold_y", {16'h0, Alu_Out}, 32'h0);
    check("bub_hold_cnz", {29'h0, C, N, Z}, 32'h5);
    drive(1, 0, 0, 3'd6, 0, 0, 0, 4'd0);            // read reg6
    check("bub_ov1b", {31'h0, out_valid}, 32'd1);
    check("bub_y2", {16'h0, Alu_Out}, 32'h0066);
    idle();
    check("bub_no_write", {16'h0, Alu_Out}, 32'h0);

    // --- Parameterized instance: 8-bit data, 16 registers ---
    for (int k = 0; k < 16; k++) drive8(1, 1, 4'(k), 0, 8'(k * 17 + 1), 1, 4'd1);
    drive8(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive8(1, 0, 0, 4'(k), 0, 0, 4'd0);
      if (k > 0) check($sformatf("p8_reg%0d", k - 1), {24'h0, p8_alu}, {24'h0, 8'((k - 1) * 17 + 1)});
    end
    drive8(0, 0, 0, 0, 0, 0, 0);
    check("p8_reg15", {24'h0, p8_alu}, 32'h0);
    drive8(1, 1, 4'd0, 0, 8'hFF, 1, 4'd1);
    drive8(0, 0, 0, 0, 0, 0, 0);
    drive8(1, 0, 0, 4'd0, 8'h01, 1, 4'd2);
    drive8(0, 0, 0, 0, 0, 0, 0);
    check("p8_add_y", {24'h0, p8_alu}, 32'h0);
    check("p8_add_cnz", {29'h0, p8_c, p8_n, p8_z}, 32'h5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
